// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, state encoding and address helpers for the SHA-256 host controller
//
// Purpose : register map of the SHA-256 core's 8-bit bus, command bytes, message limit,
//           controller state encoding and byte-to-address mapping helpers.
// Ports   : none (package).

package sha256_pkg;

  // Core register map
  localparam logic [6:0] W_START      = 7'd0;
  localparam logic [6:0] W_END        = 7'd63;
  localparam logic [6:0] WHO_AM_I     = 7'd64;
  localparam logic [6:0] STATUS       = 7'd65;
  localparam logic [6:0] DIGEST_START = 7'd70;
  localparam logic [6:0] DIGEST_END   = 7'd101;

  // Data constants
  localparam logic [7:0] WHO_AM_I_DATA = 8'd7;
  localparam logic [7:0] START_CMD     = 8'h01;
  localparam logic [7:0] ABORT_CMD     = 8'h00;
  localparam logic [7:0] PAD_MARK      = 8'h80;
  localparam int         MAX_MSG_BYTES = 55;

  typedef enum logic [3:0] {
    ST_ID,
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_START,
    ST_WAIT,
    ST_READ,
    ST_DRAIN,
    ST_ERR
  } state_t;

  // Block byte i lives at word-memory address 63-i (byte 0 is the MSB of W0).
  function automatic logic [6:0] msg_addr(input logic [5:0] i);
    return W_END - {1'b0, i};
  endfunction

  // Digest byte k lives at 101-k, so byte 0 is the MSB of word a.
  function automatic logic [6:0] digest_addr(input logic [4:0] k);
    return DIGEST_END - {2'b00, k};
  endfunction

endpackage

// File: rtl/sha256_host_ctrl_if.sv
// rtl/sha256_host_ctrl_if.sv - bundle of byte-stream, core-bus and digest-stream signals
//
// Purpose : groups the three handshake/bus groups of the host controller.
// Signals : s_data/s_valid/s_last/s_ready   message byte stream (producer -> controller)
//           o_w_addr/o_data8/o_we           core register address / write data / write enable
//           i_irq/i_data_mux                core completion pulse / combinational read data
//           m_data/m_valid/m_last/m_ready   digest byte stream (controller -> consumer)
// Modports: master = controller side, slave = producer/core/consumer side.

interface sha256_host_ctrl_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  logic [6:0] o_w_addr;
  logic [7:0] o_data8;
  logic       o_we;
  logic       i_irq;
  logic [7:0] i_data_mux;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;

  modport master (
    input  s_data, s_valid, s_last,
    output s_ready,
    output o_w_addr, o_data8, o_we,
    input  i_irq, i_data_mux,
    output m_data, m_valid, m_last,
    input  m_ready
  );

  modport slave (
    output s_data, s_valid, s_last,
    input  s_ready,
    input  o_w_addr, o_data8, o_we,
    output i_irq, i_data_mux,
    input  m_data, m_valid, m_last,
    output m_ready
  );
endinterface

// File: rtl/sha256_pad_byte.sv
// rtl/sha256_pad_byte.sv - padding byte generator for a single-block SHA-256 message
//
// Purpose : returns block byte p of the padding for a message of len bytes (len <= 55).
// Ports   : len [5:0] in   message length in bytes
//           p   [5:0] in   block byte position (len..63)
//           pad [7:0] out  byte to write at position p

module sha256_pad_byte
  import sha256_pkg::*;
(
  input  logic [5:0] len,
  input  logic [5:0] p,
  output logic [7:0] pad
);

  // Message length in bits; at most 440, so only the low two bytes of the
  // 64-bit length field are ever non-zero.
  logic [8:0] bits;
  assign bits = {len, 3'b000};

  always_comb begin
    pad = 8'h00;
    if (p == len) begin
      pad = PAD_MARK;
    end else if (p == 6'd62) begin
      pad = {7'b0000000, bits[8]};
    end else if (p == 6'd63) begin
      pad = bits[7:0];
    end
  end

endmodule

// File: rtl/sha256_host_ctrl.sv
// rtl/sha256_host_ctrl.sv - host-side bus master that pads, hashes and streams out one SHA-256 block
//
// Purpose : accepts a 1..55 byte message, writes it plus padding into the core's word memory,
//           starts the core, waits for its irq and streams the 32-byte digest MSB-first.
// Ports   : i_clk    in   clock
//           i_rst_n  in   asynchronous reset, active low
//           bus      if   sha256_host_ctrl_if.master (message stream, core bus, digest stream)
//           o_busy   out  high in every state except IDLE
//           o_err    out  sticky error, cleared by the first byte accepted in IDLE

module sha256_host_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter bit          CHECK_ID       = 1'b1
)
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  sha256_host_ctrl_if.master        bus,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam state_t     RST_STATE = CHECK_ID ? ST_ID : ST_IDLE;
  localparam logic [6:0] RST_ADDR  = CHECK_ID ? WHO_AM_I : STATUS;
  localparam logic [5:0] IDX_OVER  = 6'(MAX_MSG_BYTES);

  state_t        state_q, state_d;
  logic [5:0]    idx_q,   idx_d;
  logic [5:0]    len_q,   len_d;
  logic [6:0]    p_q,     p_d;     // 7 bits: value 64 means "padding done"
  logic [4:0]    k_q,     k_d;
  logic [TW-1:0] tmo_q,   tmo_d;
  logic [6:0]    addr_q,  addr_d;
  logic [7:0]    data_q,  data_d;
  logic          we_q,    we_d;
  logic [7:0]    md_q,    md_d;
  logic          mv_q,    mv_d;
  logic          ml_q,    ml_d;
  logic          err_q,   err_d;
  logic          busy_q;

  logic          s_ready_c;
  logic          accept;
  logic [7:0]    pad_byte;

  sha256_pad_byte u_pad (
    .len (len_q),
    .p   (p_q[5:0]),
    .pad (pad_byte)
  );

  assign s_ready_c = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign accept    = bus.s_valid && s_ready_c;

  assign bus.s_ready  = s_ready_c;
  assign bus.o_w_addr = addr_q;
  assign bus.o_data8  = data_q;
  assign bus.o_we     = we_q;
  assign bus.m_data   = md_q;
  assign bus.m_valid  = mv_q;
  assign bus.m_last   = ml_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RST_STATE;
      idx_q   <= '0;
      len_q   <= '0;
      p_q     <= '0;
      k_q     <= '0;
      tmo_q   <= '0;
      addr_q  <= RST_ADDR;
      data_q  <= '0;
      we_q    <= 1'b0;
      md_q    <= '0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      p_q     <= p_d;
      k_q     <= k_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      md_q    <= md_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
      err_q   <= err_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // All bus outputs are registered: whatever is computed here appears on the
  // core bus in the cycle after the decision (accept-to-write latency of 1).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    p_d     = p_q;
    k_d     = k_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    md_d    = md_q;
    mv_d    = mv_q;
    ml_d    = ml_q;
    err_d   = err_q;

    case (state_q)
      ST_ID: begin
        // WHO_AM_I address is already on the bus out of reset.
        if (bus.i_data_mux == WHO_AM_I_DATA) begin
          state_d = ST_IDLE;
          addr_d  = STATUS;
        end else begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end

      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          if (state_q == ST_IDLE) begin
            err_d = 1'b0;
          end
          if (idx_q == IDX_OVER) begin
            // 56th byte: message cannot fit one block, drop the rest of it.
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = bus.s_last ? ST_IDLE : ST_DRAIN;
          end else begin
            we_d   = 1'b1;
            addr_d = msg_addr(idx_q);
            data_d = bus.s_data;
            if (bus.s_last) begin
              state_d = ST_PAD;
              len_d   = idx_q + 6'd1;
              p_d     = {1'b0, idx_q} + 7'd1;
              idx_d   = '0;
            end else begin
              state_d = ST_LOAD;
              idx_d   = idx_q + 6'd1;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (accept && bus.s_last) begin
          state_d = ST_IDLE;
        end
      end

      ST_PAD: begin
        // Every byte up to 63 is rewritten since the core keeps old words.
        // The start command is registered here so it is visible in START.
        we_d = 1'b1;
        if (p_q == 7'd64) begin
          addr_d  = STATUS;
          data_d  = START_CMD;
          state_d = ST_START;
        end else begin
          addr_d = msg_addr(p_q[5:0]);
          data_d = pad_byte;
          p_d    = p_q + 7'd1;
        end
      end

      ST_START: begin
        addr_d  = STATUS;
        tmo_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.i_irq) begin
          state_d = ST_READ;
          k_d     = '0;
          addr_d  = digest_addr(5'd0);
        end else if (tmo_q == TMO_LAST) begin
          // Abort write lands in IDLE so WAIT never carries a core write.
          err_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = STATUS;
          data_d  = ABORT_CMD;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_READ: begin
        // Two phases per byte: address settles, then capture into the output
        // register; the register then holds until the consumer takes it.
        if (!mv_q) begin
          md_d = bus.i_data_mux;
          mv_d = 1'b1;
          ml_d = (k_q == 5'd31);
        end else if (bus.m_ready) begin
          mv_d = 1'b0;
          ml_d = 1'b0;
          if (k_q == 5'd31) begin
            state_d = ST_IDLE;
            addr_d  = STATUS;
          end else begin
            k_d    = k_q + 5'd1;
            addr_d = digest_addr(k_q + 5'd1);
          end
        end
      end

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// tb/tb_sha256_host_ctrl.sv - self-checking bench for sha256_host_ctrl with a behavioural SHA-256 core

module tb_sha256_host_ctrl;
  import sha256_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic o_busy, o_err;

  always #5 i_clk = ~i_clk;

  sha256_host_ctrl_if bus ();

  sha256_host_ctrl #(.TIMEOUT_CYCLES(1023), .CHECK_ID(1'b1)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus),
    .o_busy  (o_busy),
    .o_err   (o_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- SHA-256 reference ----------------
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_block(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3];
    e = H0[4]; f = H0[5]; g = H0[6]; hh = H0[7];
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + H0[0], b + H0[1], c + H0[2], d + H0[3], e + H0[4], f + H0[5], g + H0[6], hh + H0[7]};
  endfunction

  function automatic logic [511:0] pad_model(input int n, input logic [7:0] fill);
    logic [511:0] blk;
    blk = '0;
    for (int j = 0; j < n; j++) blk[511 - 8*j -: 8] = fill;
    blk[511 - 8*n -: 8] = 8'h80;
    blk[63:0] = 64'(n * 8);
    return blk;
  endfunction

  // ---------------- behavioural core ----------------
  logic [7:0] mem [128];
  logic [7:0] who = 8'd7;
  bit   irq_en = 1'b1;
  bit   no_we_window = 1'b0;
  int   irq_cd = 0;
  int   cyc = 0;
  int   start_cnt = 0, abort_cnt = 0, start_cyc = 0, abort_cyc = 0, we_in_window = 0;
  int   fill_seq = 0, fill_done = 0;
  bit   clr_window = 1'b0;

  assign bus.i_data_mux = (bus.o_w_addr == WHO_AM_I) ? who : mem[bus.o_w_addr];

  task automatic run_core();
    logic [511:0] blk;
    logic [255:0] dg;
    for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = mem[63 - j];
    dg = sha_block(blk);
    for (int k = 0; k < 32; k++) mem[101 - k] = dg[255 - 8*k -: 8];
  endtask

  always @(negedge i_clk) begin
    cyc = cyc + 1;
    if (cyc == 1) for (int j = 0; j < 128; j++) mem[j] = 8'h00;
    if (fill_seq != fill_done) begin
      for (int j = 0; j < 64; j++) mem[j] = 8'hEE;
      fill_done = fill_seq;
    end
    if (clr_window) no_we_window = 1'b0;
    bus.i_irq = 1'b0;
    if (irq_cd > 0) begin
      irq_cd = irq_cd - 1;
      if (irq_cd == 0) bus.i_irq = 1'b1;
    end
    if (i_rst_n && bus.o_we) begin
      if (no_we_window) we_in_window = we_in_window + 1;
      mem[bus.o_w_addr] = bus.o_data8;
      if (bus.o_w_addr == STATUS && bus.o_data8 == START_CMD) begin
        start_cnt = start_cnt + 1;
        start_cyc = cyc;
        run_core();
        if (irq_en) begin
          irq_cd = 20;
          no_we_window = 1'b1;
        end
      end else if (bus.o_w_addr == STATUS && bus.o_data8 == ABORT_CMD) begin
        abort_cnt = abort_cnt + 1;
        abort_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] tx_buf [64];

  task automatic send_buf(input int n, input bit chk_first);
    int guard;
    for (int i = 0; i < n; i++) begin
      bus.s_data  = tx_buf[i];
      bus.s_valid = 1'b1;
      bus.s_last  = (i == n - 1);
      guard = 0;
      while (!bus.s_ready && guard < 200) begin
        @(negedge i_clk);
        guard++;
      end
      if (!bus.s_ready) begin
        fail("s_ready");
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        return;
      end
      @(negedge i_clk);
      if (chk_first && i == 0) begin
        check("first_write_we",   bus.o_we, 1);
        check("first_write_addr", bus.o_w_addr, 63);
        check("first_write_data", bus.o_data8, tx_buf[0]);
        check("err_cleared",      o_err, 0);
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic recv_digest(output logic [255:0] dg, input int stall_k, input int stall_n);
    int guard;
    int last_errs;
    int stable_errs;
    logic [7:0] held;
    dg = '0;
    last_errs = 0;
    stable_errs = 0;
    bus.m_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      guard = 0;
      while (!bus.m_valid && guard < 500) begin
        @(negedge i_clk);
        guard++;
      end
      if (!bus.m_valid) begin
        fail("m_valid");
        return;
      end
      if (k == stall_k) begin
        held = bus.m_data;
        repeat (stall_n) begin
          @(negedge i_clk);
          if (bus.m_data !== held || bus.m_valid !== 1'b1) stable_errs++;
        end
      end
      if (bus.m_last !== (k == 31)) last_errs++;
      dg[255 - 8*k -: 8] = bus.m_data;
      bus.m_ready = 1'b1;
      @(negedge i_clk);
      bus.m_ready = 1'b0;
    end
    check("m_last_position", last_errs, 0);
    if (stall_n > 0) check("m_data_stable_on_stall", stable_errs, 0);
    check("busy_after_digest", o_busy, 0);
    check("no_we_wait_read", we_in_window, 0);
    clr_window = 1'b1;
    @(negedge i_clk);
    clr_window = 1'b0;
  endtask

  // ---------------- memory image vectors ----------------
  typedef struct {
    int         tcase;
    logic [6:0] addr;
    logic [7:0] exp;
  } mem_vec_t;

  mem_vec_t vec [20];

  task automatic check_mem(input int tcase);
    for (int i = 0; i < 20; i++) begin
      if (vec[i].tcase == tcase)
        check($sformatf("mem_case%0d_addr%0d", tcase, vec[i].addr), mem[vec[i].addr], vec[i].exp);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [255:0] dg;
    int guard;
    int prev;
    int rdy_seen;

    vec[0]  = '{0, 7'd63, 8'h61}; vec[1]  = '{0, 7'd62, 8'h62}; vec[2]  = '{0, 7'd61, 8'h63};
    vec[3]  = '{0, 7'd60, 8'h80}; vec[4]  = '{0, 7'd59, 8'h00}; vec[5]  = '{0, 7'd30, 8'h00};
    vec[6]  = '{0, 7'd1,  8'h00}; vec[7]  = '{0, 7'd0,  8'h18};
    vec[8]  = '{1, 7'd63, 8'h61}; vec[9]  = '{1, 7'd9,  8'h61}; vec[10] = '{1, 7'd8,  8'h80};
    vec[11] = '{1, 7'd7,  8'h00}; vec[12] = '{1, 7'd1,  8'h01}; vec[13] = '{1, 7'd0,  8'hb8};
    vec[14] = '{2, 7'd63, 8'h41}; vec[15] = '{2, 7'd9,  8'h41}; vec[16] = '{2, 7'd8,  8'hEE};
    vec[17] = '{2, 7'd0,  8'hEE}; vec[18] = '{3, 7'd65, 8'h00}; vec[19] = '{3, 7'd60, 8'h80};

    bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);

    // reset values
    check("rst_addr",    bus.o_w_addr, 64);
    check("rst_we",      bus.o_we, 0);
    check("rst_data8",   bus.o_data8, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last",  bus.m_last, 0);
    check("rst_m_data",  bus.m_data, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_busy",    o_busy, 0);
    check("rst_err",     o_err, 0);

    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("id_ok_ready", bus.s_ready, 1);
    check("id_ok_addr",  bus.o_w_addr, 65);
    check("id_ok_err",   o_err, 0);

    // 1: "abc" over stale block contents
    fill_seq++;
    repeat (2) @(negedge i_clk);
    tx_buf[0] = 8'h61; tx_buf[1] = 8'h62; tx_buf[2] = 8'h63;
    send_buf(3, 1'b1);
    check("busy_during_pad", o_busy, 1);
    recv_digest(dg, -1, 0);
    check("abc_digest", dg, ABC_DIGEST);
    check_mem(0);
    check("abc_start_count", start_cnt, 1);

    // 2: 55 bytes of 'a'
    fill_seq++;
    repeat (2) @(negedge i_clk);
    for (int i = 0; i < 55; i++) tx_buf[i] = 8'h61;
    send_buf(55, 1'b1);
    recv_digest(dg, -1, 0);
    check("a55_digest", dg, sha_block(pad_model(55, 8'h61)));
    check_mem(1);

    // 3: oversize messages, with and without drain
    fill_seq++;
    repeat (2) @(negedge i_clk);
    prev = start_cnt;
    for (int i = 0; i < 58; i++) tx_buf[i % 64] = 8'h41;
    send_buf(56, 1'b0);
    repeat (3) @(negedge i_clk);
    check("over56_err",   o_err, 1);
    check("over56_busy",  o_busy, 0);
    check("over56_start", start_cnt, prev);
    check_mem(2);
    send_buf(58, 1'b0);
    repeat (3) @(negedge i_clk);
    check("over58_err",   o_err, 1);
    check("over58_busy",  o_busy, 0);
    check("over58_start", start_cnt, prev);
    tx_buf[0] = 8'h61; tx_buf[1] = 8'h62; tx_buf[2] = 8'h63;
    send_buf(3, 1'b1);
    recv_digest(dg, -1, 0);
    check("after_err_digest", dg, ABC_DIGEST);

    // 5: no irq -> timeout abort
    irq_en = 1'b0;
    prev = abort_cnt;
    send_buf(3, 1'b1);
    guard = 0;
    while (abort_cnt == prev && guard < 1500) begin
      @(negedge i_clk);
      guard++;
    end
    if (abort_cnt == prev) fail("abort_write");
    else begin
      check("timeout_delay", abort_cyc - start_cyc, 1024);
      check("timeout_err",   o_err, 1);
      check("timeout_busy",  o_busy, 0);
      check_mem(3);
    end

    // 6: consumer stall on digest byte 3
    irq_en = 1'b1;
    repeat (2) @(negedge i_clk);
    send_buf(3, 1'b1);
    recv_digest(dg, 3, 10);
    check("stall_digest", dg, ABC_DIGEST);

    // reset pulse during WAIT
    irq_en = 1'b0;
    prev = start_cnt;
    send_buf(3, 1'b1);
    guard = 0;
    while (start_cnt == prev && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    if (start_cnt == prev) fail("start_write");
    repeat (5) @(negedge i_clk);
    check("wait_busy", o_busy, 1);
    i_rst_n = 1'b0;
    #1;
    check("midrst_addr",    bus.o_w_addr, 64);
    check("midrst_we",      bus.o_we, 0);
    check("midrst_busy",    o_busy, 0);
    check("midrst_s_ready", bus.s_ready, 0);
    check("midrst_m_valid", bus.m_valid, 0);

    // 4: wrong WHO_AM_I locks in error
    who = 8'h05;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h61;
    rdy_seen = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (bus.s_ready) rdy_seen++;
    end
    bus.s_valid = 1'b0;
    check("badid_err",    o_err, 1);
    check("badid_busy",   o_busy, 1);
    check("badid_ready",  rdy_seen, 0);

    who = 8'h07;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    check("reid_ready", bus.s_ready, 1);
    check("reid_err",   o_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
